contador_sincrono: RTL and testbench
====================================

CONTADOR_SINCRONO -- requirements
Module: contador_sincrono

Interface
REQ-001 Parameter: WIDTH, default 6, counter width in bits; all requirements below use WIDTH=6.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: clr  input  1  asynchronous, active-low reset (clear).
REQ-004 Port: q  output  [5:0]  current count value, driven directly from the state flip-flops.
REQ-005 The positional port order SHALL be (q, clr, clk) so that positional instantiation binds correctly.
REQ-006 There is exactly one clock; the reset is asynchronous and active-low; the block SHALL have no other ports.

Function
REQ-007 The block SHALL be a synchronous modulo-64 down counter; all bits SHALL be clocked by the same clk edge, with no ripple clocking.
REQ-008 With clr high, each rising clk edge SHALL load q <= q - 1 (mod 64); latency is one cycle, with no enable and no hold state.
REQ-009 Wrap-around: from q=0 the next edge SHALL give q=63; from q=1 the next edge SHALL give q=0.
REQ-010 The block SHALL be built structurally from WIDTH toggle (T) flip-flop stages in a dedicated T flip-flop submodule with async active-low clear. Each stage SHALL be instantiated and chained through explicit toggle-enable nets.
REQ-011 Toggle logic: bit 0 SHALL toggle on every edge. Bit i (i>0) SHALL toggle only when bits 0..i-1 are all 0, i.e. t[i] = t[i-1] AND NOT q[i-1], with t[0]=1.
REQ-012 The toggle-enable chain SHALL be pure combinational logic from q; it SHALL NOT feed back q via any clock path.
REQ-013 q SHALL never be X/Z after the first reset assertion.
REQ-014 Arithmetic SHALL be unsigned; no carry or borrow output is produced.

Reset
REQ-015 While clr=0, q SHALL be 6'd0 immediately, without waiting for a clk edge, and SHALL hold 0 regardless of clk.
REQ-016 On clr deasserting (0->1), the first rising clk edge with clr=1 SHALL yield q=63.
REQ-017 Reset asserted mid-count SHALL clear q to 0 at once. Counting SHALL resume from 0 (next value 63) after release.
REQ-018 If clr rises coincident with a clk edge, that edge MAY be ignored. The bench SHALL release clr away from rising edges (e.g. on a falling edge).

Verification
REQ-019 Drive clr=0, toggle clk, with 20 ns period -> q=0 throughout, including between edges.
REQ-020 Release clr on a falling edge, then apply 27 rising edges -> q sequence 63, 62, ..., 37 with exactly -1 per edge.
REQ-021 Apply 64 consecutive edges from q=0 -> q returns to 0, and every value 63..0 appears exactly once in descending order.
REQ-022 Boundaries: q=1 -> next edge gives 0; q=0 -> next edge gives 63; q=32 -> next edge gives 31, where bits 0-4 toggle to 1 and bit 5 toggles to 0.
REQ-023 Pull clr low between clock edges while q=45 -> q=0 before the next edge; after release, the next edge gives q=63.
REQ-024 Hold clk static with clr=1 for 100 ns -> q stays unchanged.

Source files
------------

// File: rtl/contador_sincrono.sv
// Synchronous modulo-2^WIDTH down counter assembled from T flip-flop stages.
// All stages share one clock; the toggle-enable chain is combinational from q.

module contador_sincrono_tff (
  input  logic clk,
  input  logic clr,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

module contador_sincrono #(
  parameter int WIDTH = 6
) (
  output logic [WIDTH-1:0] q,
  input  logic             clr,
  input  logic             clk
);

  // t[i] is high when every lower bit is zero, which is exactly when a
  // borrow propagates into bit i while counting down.
  logic [WIDTH-1:0] t;

  assign t[0] = 1'b1;

  genvar i;
  generate
    for (i = 1; i < WIDTH; i++) begin : g_chain
      assign t[i] = t[i-1] & ~q[i-1];
    end

    for (i = 0; i < WIDTH; i++) begin : g_stage
      contador_sincrono_tff u_tff (
        .clk (clk),
        .clr (clr),
        .t   (t[i]),
        .q   (q[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_contador_sincrono.sv
// Bench for contador_sincrono: reset behaviour, a vector table, hand-written
// corner sequences and a randomized run against an arithmetic reference model.

module tb_contador_sincrono;

  localparam int W = 6;

  logic         clk;
  logic         clr;
  logic         run;
  logic [W-1:0] q;

  int n_tests;
  int n_fail;
  int m;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         clr;
    int           edges;
    logic [W-1:0] expect_q;
  } vec_t;

  vec_t vecs[12];

  contador_sincrono #(.WIDTH(W)) dut (
    .q   (q),
    .clr (clr),
    .clk (clk)
  );

  // clock / reset block: 20 ns period, can be frozen with run=0
  initial begin
    clk = 1'b0;
    run = 1'b1;
    forever begin
      #10;
      if (run) clk = ~clk;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog q=%0d required=finish", q);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s q=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply_vec(input int idx);
    @(negedge clk);
    clr = vecs[idx].clr;
    #1;
    for (int e = 0; e < vecs[idx].edges; e++) begin
      @(posedge clk);
    end
    #1;
    check($sformatf("vec%0d", idx), q, vecs[idx].expect_q);
  endtask

  task automatic model_edge();
    @(posedge clk);
    m = (m + 63) % 64;
    exp_q.push_back(m[W-1:0]);
    #1;
    check("random_edge", q, exp_q.pop_front());
  endtask

  initial begin
    int seen[64];
    logic [W-1:0] held;
    n_tests = 0;
    n_fail  = 0;
    m       = 0;
    clr     = 1'b0;

    vecs[0]  = '{1'b0, 0,  6'd0};
    vecs[1]  = '{1'b1, 1,  6'd63};
    vecs[2]  = '{1'b1, 30, 6'd33};
    vecs[3]  = '{1'b1, 1,  6'd32};
    vecs[4]  = '{1'b1, 1,  6'd31};
    vecs[5]  = '{1'b1, 30, 6'd1};
    vecs[6]  = '{1'b1, 1,  6'd0};
    vecs[7]  = '{1'b1, 1,  6'd63};
    vecs[8]  = '{1'b1, 18, 6'd45};
    vecs[9]  = '{1'b0, 0,  6'd0};
    vecs[10] = '{1'b0, 3,  6'd0};
    vecs[11] = '{1'b1, 1,  6'd63};

    // reset held: q is zero at and between edges
    #1;
    check("reset_t0", q, 6'd0);
    n_tests++;
    if ($isunknown(q)) begin
      n_fail++;
      $display("FAIL reset_known q=%b required=000000", q);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("reset_posedge", q, 6'd0);
      #4;
      check("reset_mid", q, 6'd0);
      @(negedge clk); #1;
      check("reset_negedge", q, 6'd0);
    end

    // release on a falling edge, 27 edges: 63 down to 37
    @(negedge clk);
    clr = 1'b1;
    m = 0;
    for (int e = 0; e < 27; e++) begin
      @(posedge clk); #1;
      m = (m + 63) % 64;
      check("release_seq", q, m[W-1:0]);
    end
    check("release_end", q, 6'd37);

    for (int i = 0; i < 12; i++) apply_vec(i);

    // full cycle of 64 edges from zero
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("cycle_clear", q, 6'd0);
    @(negedge clk);
    clr = 1'b1;
    for (int v = 0; v < 64; v++) seen[v] = 0;
    for (int e = 0; e < 64; e++) begin
      @(posedge clk); #1;
      seen[q]++;
      check("cycle_seq", q, 6'(63 - e));
    end
    check("cycle_wrap", q, 6'd0);
    for (int v = 0; v < 64; v++) begin
      n_tests++;
      if (seen[v] != 1) begin
        n_fail++;
        $display("FAIL cycle_once value=%0d count=%0d required=1", v, seen[v]);
      end
    end

    // clock frozen for 100 ns with clr high
    @(negedge clk);
    m = 0;
    model_edge();
    model_edge();
    model_edge();
    @(negedge clk);
    run = 1'b0;
    held = q;
    #100;
    check("static_clk", q, 6'(m));
    check("static_hold", q, held);
    run = 1'b1;

    // randomized run against the arithmetic model
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #($urandom_range(2, 8));
        clr = 1'b0;
        m = 0;
        #1;
        check("random_clear", q, 6'd0);
        @(negedge clk);
        clr = 1'b1;
      end else begin
        repeat ($urandom_range(1, 12)) model_edge();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
